aurora_adc_pattern_chk: RTL and testbench
=========================================

// Module: aurora_adc_pattern_chk
// PURPOSE
//  Self-synchronising checker for the multi-lane incrementing ADC test pattern on the Aurora RX path.
//  Hunts for pattern alignment, then locks and counts good/bad beats. Drops lock after repeated failures.
//  Captures the first error and a sticky per-lane error mask for register readback.
//  Sits after the Aurora user-data deframer in the per-link debug/BIST logic.
// PARAMETERS
//  LANES      8   samples per beat; DATA_WD = LANES*SAMPLE_WD (localparam)
//  SAMPLE_WD  16  bits per sample
//  PERIOD     4   lane i expects base + (i % PERIOD)
//  INC        4   amount base advances each time it advances
//  REPEAT     4   beats per base value (1..16); base advances after the REPEAT-th beat
//  LOCK_CNT   8   consecutive good beats needed to reach LOCKED (>=1)
//  LOSS_CNT   4   consecutive bad beats in LOCKED that force HUNT (>=1)
// PORTS
//  clk            in   1          data clock
//  rst_n          in   1          asynchronous, active-low reset
//  cfg_rst        in   1          synchronous clear of all state/counters, priority over adc_vld
//  adc_vld        in   1          beat valid
//  adc_data       in   DATA_WD    beat; lane i = adc_data[i*SAMPLE_WD +: SAMPLE_WD]
//  locked         out  1          state==LOCKED
//  suc_cnt        out  32         good beats seen while LOCKED
//  err_cnt        out  32         bad beats seen while LOCKED
//  loss_cnt       out  16         LOCKED->HUNT transitions
//  err_lane_mask  out  LANES      sticky OR of per-lane mismatches while LOCKED
//  first_err_vld  out  1          first-error capture is valid
//  first_err_exp  out  SAMPLE_WD  expected base at first error
//  first_err_mask out  LANES      lane mismatch mask of first error beat
// BEHAVIOUR
//  Reset (rst_n low or cfg_rst): state=HUNT; all outputs 0; base, phase (beat-in-base) and run counters 0.
//  All updates occur on the clk edge at which adc_vld=1 is sampled; outputs are visible next cycle. No backpressure.
//  Expected lane i = base + (i % PERIOD), modulo 2^SAMPLE_WD. mism[i] = lane mismatch. A beat is good when mism==0.
//  Expected advance (VERIFY/LOCKED, every vld, good or bad):
//    phase==REPEAT-1 -> phase=0, base+=INC (wrap)
//    else            -> phase+=1
//  Because the expected value advances on bad beats too, one corrupt beat does not misalign the checker.
//  HUNT: on vld, a beat is self-consistent when lane i == lane0 + (i % PERIOD) for all i.
//    Self-consistent -> seed base=lane0, phase=1 (phase=0 and base=lane0+INC if REPEAT==1).
//      good_run=1. Go to LOCKED if LOCK_CNT==1, else VERIFY.
//    Not self-consistent -> stay in HUNT. No counters change.
//  VERIFY: good beat -> good_run+1; when good_run+1==LOCK_CNT go to LOCKED. Bad beat -> HUNT, good_run=0.
//  LOCKED:
//    Good beat: suc_cnt+1, bad_run=0.
//    Bad beat: err_cnt+1, err_lane_mask|=mism, bad_run+1.
//      If first_err_vld==0: capture first_err_exp=base and first_err_mask=mism, then set first_err_vld.
//      If bad_run+1==LOSS_CNT: go to HUNT, loss_cnt+1, bad_run=0.
//  Seeding assumes the beat is phase 0 of its base. A mis-phased seed fails in VERIFY and re-hunts.
//  Counters saturate at all-ones and do not wrap. cfg_rst clears the first-error capture; lock loss does not.
//  rst_n asserted mid-operation: immediate clear. Link up after release of rst_n/cfg_rst starts in HUNT.
// TESTING
//  T1 Defaults, clean pattern seeded 0x0000, 100 beats -> locked rises after beat 8.
//     suc_cnt=92, err_cnt=0. The 100 beats carry bases 0,4,...,96, 4 beats per base.
//  T2 After lock, corrupt lane 5 of one beat -> err_cnt=1.
//     err_lane_mask=0x20, first_err_mask=0x20, first_err_exp=the base of that beat. Lock is held.
//     Following clean beats increment suc_cnt.
//  T3 After lock, 4 consecutive bad beats -> locked=0, loss_cnt=1.
//     Clean data with new seed 0x1234 -> relock after 8 beats.
//  T4 Seed 0xFFF8 -> base wraps to 0x0000/0x0004; no errors. Covers lane-value wrap 0xFFFF->0x0000.
//  T5 HUNT with inconsistent beats (lane1!=lane0+1) -> stays HUNT, all counters 0.
//     Seed on a mid-REPEAT beat -> VERIFY fails and re-hunts.
//  T6 cfg_rst asserted together with adc_vld in LOCKED -> all outputs 0 next cycle, state HUNT.
//     Repeat the test with LANES=4, PERIOD=2, INC=2, REPEAT=1.

Source files
------------

// File: rtl/aurora_adc_pattern_chk.sv
// rtl/aurora_adc_pattern_chk.sv - self-synchronising multi-lane incrementing ADC pattern checker
// Hunts for a self-consistent beat, verifies alignment, then counts good/bad beats while locked.
module aurora_adc_pattern_chk #(
   parameter  int LANES     = 8,
   parameter  int SAMPLE_WD = 16,
   parameter  int PERIOD    = 4,
   parameter  int INC       = 4,
   parameter  int REPEAT    = 4,
   parameter  int LOCK_CNT  = 8,
   parameter  int LOSS_CNT  = 4,
   localparam int DATA_WD   = LANES * SAMPLE_WD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_rst,
   input  logic                 adc_vld,
   input  logic [DATA_WD-1:0]   adc_data,
   output logic                 locked,
   output logic [31:0]          suc_cnt,
   output logic [31:0]          err_cnt,
   output logic [15:0]          loss_cnt,
   output logic [LANES-1:0]     err_lane_mask,
   output logic                 first_err_vld,
   output logic [SAMPLE_WD-1:0] first_err_exp,
   output logic [LANES-1:0]     first_err_mask
);

   localparam int PH_WD   = 4;
   localparam int GRUN_WD = $clog2(LOCK_CNT + 1);
   localparam int BRUN_WD = $clog2(LOSS_CNT + 1);

   typedef enum logic [1:0] {HUNT, VERIFY, LCKD} state_t;

   state_t               state_q, state_d;
   logic [SAMPLE_WD-1:0] base_q, base_d;
   logic [PH_WD-1:0]     phase_q, phase_d;
   logic [GRUN_WD-1:0]   good_run_q, good_run_d;
   logic [BRUN_WD-1:0]   bad_run_q, bad_run_d;
   logic [31:0]          suc_cnt_q, suc_cnt_d;
   logic [31:0]          err_cnt_q, err_cnt_d;
   logic [15:0]          loss_cnt_q, loss_cnt_d;
   logic [LANES-1:0]     err_lane_mask_q, err_lane_mask_d;
   logic                 first_err_vld_q, first_err_vld_d;
   logic [SAMPLE_WD-1:0] first_err_exp_q, first_err_exp_d;
   logic [LANES-1:0]     first_err_mask_q, first_err_mask_d;

   logic [LANES-1:0]     mism;
   logic [LANES-1:0]     hunt_mism;
   logic [SAMPLE_WD-1:0] src_base, adv_base;
   logic [PH_WD-1:0]     src_phase, adv_phase;

   function automatic logic [31:0] sat32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   always_comb begin
      mism      = '0;
      hunt_mism = '0;
      for (int i = 0; i < LANES; i++) begin
         mism[i]      = adc_data[i*SAMPLE_WD +: SAMPLE_WD] != base_q + SAMPLE_WD'(i % PERIOD);
         hunt_mism[i] = adc_data[i*SAMPLE_WD +: SAMPLE_WD] !=
                        adc_data[SAMPLE_WD-1:0] + SAMPLE_WD'(i % PERIOD);
      end

      // A HUNT seed is the advance applied to (lane0, phase 0), which covers REPEAT==1 too.
      src_base  = (state_q == HUNT) ? adc_data[SAMPLE_WD-1:0] : base_q;
      src_phase = (state_q == HUNT) ? '0 : phase_q;
      if (src_phase == PH_WD'(REPEAT - 1)) begin
         adv_phase = '0;
         adv_base  = src_base + SAMPLE_WD'(INC);
      end else begin
         adv_phase = src_phase + PH_WD'(1);
         adv_base  = src_base;
      end

      state_d          = state_q;
      base_d           = base_q;
      phase_d          = phase_q;
      good_run_d       = good_run_q;
      bad_run_d        = bad_run_q;
      suc_cnt_d        = suc_cnt_q;
      err_cnt_d        = err_cnt_q;
      loss_cnt_d       = loss_cnt_q;
      err_lane_mask_d  = err_lane_mask_q;
      first_err_vld_d  = first_err_vld_q;
      first_err_exp_d  = first_err_exp_q;
      first_err_mask_d = first_err_mask_q;

      if (cfg_rst) begin
         state_d          = HUNT;
         base_d           = '0;
         phase_d          = '0;
         good_run_d       = '0;
         bad_run_d        = '0;
         suc_cnt_d        = '0;
         err_cnt_d        = '0;
         loss_cnt_d       = '0;
         err_lane_mask_d  = '0;
         first_err_vld_d  = 1'b0;
         first_err_exp_d  = '0;
         first_err_mask_d = '0;
      end else if (adc_vld) begin
         case (state_q)
            HUNT: begin
               if (hunt_mism == '0) begin
                  base_d     = adv_base;
                  phase_d    = adv_phase;
                  good_run_d = GRUN_WD'(1);
                  state_d    = (LOCK_CNT == 1) ? LCKD : VERIFY;
               end
            end
            VERIFY: begin
               base_d  = adv_base;
               phase_d = adv_phase;
               if (mism == '0) begin
                  good_run_d = good_run_q + GRUN_WD'(1);
                  if (good_run_q + GRUN_WD'(1) == GRUN_WD'(LOCK_CNT))
                     state_d = LCKD;
               end else begin
                  good_run_d = '0;
                  state_d    = HUNT;
               end
            end
            LCKD: begin
               base_d  = adv_base;
               phase_d = adv_phase;
               if (mism == '0) begin
                  suc_cnt_d = sat32(suc_cnt_q);
                  bad_run_d = '0;
               end else begin
                  err_cnt_d       = sat32(err_cnt_q);
                  err_lane_mask_d = err_lane_mask_q | mism;
                  bad_run_d       = bad_run_q + BRUN_WD'(1);
                  if (!first_err_vld_q) begin
                     first_err_vld_d  = 1'b1;
                     first_err_exp_d  = base_q;
                     first_err_mask_d = mism;
                  end
                  if (bad_run_q + BRUN_WD'(1) == BRUN_WD'(LOSS_CNT)) begin
                     state_d    = HUNT;
                     loss_cnt_d = sat16(loss_cnt_q);
                     bad_run_d  = '0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= HUNT;
         base_q           <= '0;
         phase_q          <= '0;
         good_run_q       <= '0;
         bad_run_q        <= '0;
         suc_cnt_q        <= '0;
         err_cnt_q        <= '0;
         loss_cnt_q       <= '0;
         err_lane_mask_q  <= '0;
         first_err_vld_q  <= 1'b0;
         first_err_exp_q  <= '0;
         first_err_mask_q <= '0;
      end else begin
         state_q          <= state_d;
         base_q           <= base_d;
         phase_q          <= phase_d;
         good_run_q       <= good_run_d;
         bad_run_q        <= bad_run_d;
         suc_cnt_q        <= suc_cnt_d;
         err_cnt_q        <= err_cnt_d;
         loss_cnt_q       <= loss_cnt_d;
         err_lane_mask_q  <= err_lane_mask_d;
         first_err_vld_q  <= first_err_vld_d;
         first_err_exp_q  <= first_err_exp_d;
         first_err_mask_q <= first_err_mask_d;
      end
   end

   assign locked         = (state_q == LCKD);
   assign suc_cnt        = suc_cnt_q;
   assign err_cnt        = err_cnt_q;
   assign loss_cnt       = loss_cnt_q;
   assign err_lane_mask  = err_lane_mask_q;
   assign first_err_vld  = first_err_vld_q;
   assign first_err_exp  = first_err_exp_q;
   assign first_err_mask = first_err_mask_q;

endmodule

// File: tb/tb_aurora_adc_pattern_chk.sv
// tb/tb_aurora_adc_pattern_chk.sv - directed self-checking bench for aurora_adc_pattern_chk
// Instance a uses defaults; instance b uses LANES=4, PERIOD=2, INC=2, REPEAT=1.
module tb_aurora_adc_pattern_chk;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         cfg_rst;
   logic         adc_vld;
   logic [127:0] adc_data;
   logic         locked;
   logic [31:0]  suc_cnt, err_cnt;
   logic [15:0]  loss_cnt;
   logic [7:0]   err_lane_mask, first_err_mask;
   logic         first_err_vld;
   logic [15:0]  first_err_exp;

   logic         cfg_rst_b;
   logic         adc_vld_b;
   logic [63:0]  adc_data_b;
   logic         locked_b;
   logic [31:0]  suc_cnt_b, err_cnt_b;
   logic [15:0]  loss_cnt_b;
   logic [3:0]   err_lane_mask_b, first_err_mask_b;
   logic         first_err_vld_b;
   logic [15:0]  first_err_exp_b;

   int n_cmp = 0;
   int n_mis = 0;

   aurora_adc_pattern_chk u_dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .adc_vld(adc_vld), .adc_data(adc_data),
      .locked(locked), .suc_cnt(suc_cnt), .err_cnt(err_cnt), .loss_cnt(loss_cnt),
      .err_lane_mask(err_lane_mask), .first_err_vld(first_err_vld),
      .first_err_exp(first_err_exp), .first_err_mask(first_err_mask)
   );

   aurora_adc_pattern_chk #(.LANES(4), .PERIOD(2), .INC(2), .REPEAT(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst_b), .adc_vld(adc_vld_b), .adc_data(adc_data_b),
      .locked(locked_b), .suc_cnt(suc_cnt_b), .err_cnt(err_cnt_b), .loss_cnt(loss_cnt_b),
      .err_lane_mask(err_lane_mask_b), .first_err_vld(first_err_vld_b),
      .first_err_exp(first_err_exp_b), .first_err_mask(first_err_mask_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, ".locked"}, 32'(locked), 32'h0);
      chk({tag, ".suc"}, suc_cnt, 32'h0);
      chk({tag, ".err"}, err_cnt, 32'h0);
      chk({tag, ".loss"}, 32'(loss_cnt), 32'h0);
      chk({tag, ".mask"}, 32'(err_lane_mask), 32'h0);
      chk({tag, ".fev"}, 32'(first_err_vld), 32'h0);
      chk({tag, ".fee"}, 32'(first_err_exp), 32'h0);
      chk({tag, ".fem"}, 32'(first_err_mask), 32'h0);
   endtask

   function automatic logic [127:0] pat8(input logic [15:0] base);
      logic [127:0] d;
      for (int i = 0; i < 8; i++) d[i*16 +: 16] = base + 16'(i % 4);
      return d;
   endfunction

   function automatic logic [63:0] pat4(input logic [15:0] base);
      logic [63:0] d;
      for (int i = 0; i < 4; i++) d[i*16 +: 16] = base + 16'(i % 2);
      return d;
   endfunction

   task automatic beat(input logic [127:0] d);
      @(negedge clk);
      adc_vld  = 1'b1;
      adc_data = d;
      @(posedge clk);
      #1;
      adc_vld  = 1'b0;
   endtask

   task automatic beat_b(input logic [63:0] d);
      @(negedge clk);
      adc_vld_b  = 1'b1;
      adc_data_b = d;
      @(posedge clk);
      #1;
      adc_vld_b  = 1'b0;
   endtask

   task automatic pulse_cfg_rst;
      @(negedge clk);
      cfg_rst = 1'b1;
      @(posedge clk);
      #1;
      cfg_rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d;
      logic [63:0]  db;

      rst_n = 1'b0; cfg_rst = 1'b0; adc_vld = 1'b0; adc_data = '0;
      cfg_rst_b = 1'b0; adc_vld_b = 1'b0; adc_data_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_zero_a("reset");
      chk("reset.b.locked", 32'(locked_b), 32'h0);

      // T1: clean stream from base 0, four beats per base
      for (int k = 0; k < 100; k++) begin
         beat(pat8(16'(4 * (k / 4))));
         if (k == 6) chk("t1.unlocked_after_7", 32'(locked), 32'h0);
         if (k == 7) chk("t1.locked_after_8", 32'(locked), 32'h1);
      end
      chk("t1.suc", suc_cnt, 32'd92);
      chk("t1.err", err_cnt, 32'd0);

      // T2: corrupt lane 5 of the beat carrying base 0x64
      d = pat8(16'h0064);
      d[5*16 +: 16] = d[5*16 +: 16] ^ 16'h0001;
      beat(d);
      chk("t2.err", err_cnt, 32'd1);
      chk("t2.mask", 32'(err_lane_mask), 32'h20);
      chk("t2.fem", 32'(first_err_mask), 32'h20);
      chk("t2.fee", 32'(first_err_exp), 32'h64);
      chk("t2.fev", 32'(first_err_vld), 32'h1);
      chk("t2.locked", 32'(locked), 32'h1);
      for (int k = 101; k < 104; k++) beat(pat8(16'(4 * (k / 4))));
      chk("t2.suc", suc_cnt, 32'd95);

      // T3: four consecutive bad beats (lane 0) drop lock
      for (int k = 104; k < 108; k++) begin
         d = pat8(16'(4 * (k / 4)));
         d[15:0] = d[15:0] + 16'h0100;
         beat(d);
         if (k == 106) chk("t3.still_locked", 32'(locked), 32'h1);
      end
      chk("t3.locked", 32'(locked), 32'h0);
      chk("t3.loss", 32'(loss_cnt), 32'd1);
      chk("t3.err", err_cnt, 32'd5);
      chk("t3.mask", 32'(err_lane_mask), 32'h21);
      chk("t3.fee_kept", 32'(first_err_exp), 32'h64);
      chk("t3.fem_kept", 32'(first_err_mask), 32'h20);
      for (int j = 0; j < 12; j++) begin
         beat(pat8(16'(32'h1234 + 4 * (j / 4))));
         if (j == 6) chk("t3.relock_pending", 32'(locked), 32'h0);
         if (j == 7) chk("t3.relocked", 32'(locked), 32'h1);
      end
      chk("t3.suc", suc_cnt, 32'd99);
      chk("t3.err_after", err_cnt, 32'd5);

      // T4: base wraps 0xFFF8 -> 0xFFFC -> 0x0000 -> 0x0004
      pulse_cfg_rst();
      chk_zero_a("t4.cfg_rst");
      for (int j = 0; j < 16; j++) beat(pat8(16'(32'hFFF8 + 4 * (j / 4))));
      chk("t4.locked", 32'(locked), 32'h1);
      chk("t4.suc", suc_cnt, 32'd8);
      chk("t4.err", err_cnt, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t4.async_locked", 32'(locked), 32'h0);
      chk("t4.async_suc", suc_cnt, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // T5: inconsistent beats never seed; a mid-REPEAT seed keeps re-hunting
      d = pat8(16'h0100);
      d[31:16] = d[31:16] + 16'd5;
      for (int k = 0; k < 10; k++) beat(d);
      chk("t5.incons_locked", 32'(locked), 32'h0);
      beat(pat8(16'h0100));
      for (int k = 1; k < 9; k++) beat(d);
      chk("t5.verify_bad_locked", 32'(locked), 32'h0);
      for (int k = 2; k < 42; k++) beat(pat8(16'(32'h0200 + 4 * (k / 4))));
      chk("t5.midphase_locked", 32'(locked), 32'h0);
      chk("t5.suc", suc_cnt, 32'h0);
      chk("t5.err", err_cnt, 32'h0);
      chk("t5.loss", 32'(loss_cnt), 32'h0);

      // T6: cfg_rst wins over a valid beat while locked
      pulse_cfg_rst();
      for (int k = 0; k < 10; k++) beat(pat8(16'(4 * (k / 4))));
      d = pat8(16'h0008);
      d[3*16 +: 16] = 16'h0000;
      beat(d);
      chk("t6.pre_err", err_cnt, 32'd1);
      chk("t6.pre_fem", 32'(first_err_mask), 32'h08);
      @(negedge clk);
      cfg_rst  = 1'b1;
      adc_vld  = 1'b1;
      adc_data = pat8(16'h0008);
      @(posedge clk);
      #1;
      cfg_rst = 1'b0;
      adc_vld = 1'b0;
      chk_zero_a("t6.cfg_rst_vld");
      beat(pat8(16'h000C));
      chk("t6.hunt_after", 32'(locked), 32'h0);

      // Alternate parameter set: base advances by 2 every beat
      for (int k = 0; k < 10; k++) begin
         beat_b(pat4(16'(2 * k)));
         if (k == 6) chk("b.unlocked_after_7", 32'(locked_b), 32'h0);
         if (k == 7) chk("b.locked_after_8", 32'(locked_b), 32'h1);
      end
      chk("b.suc", suc_cnt_b, 32'd2);
      db = pat4(16'd20);
      db[2*16 +: 16] = db[2*16 +: 16] ^ 16'h8000;
      beat_b(db);
      chk("b.err", err_cnt_b, 32'd1);
      chk("b.mask", 32'(err_lane_mask_b), 32'h4);
      chk("b.fee", 32'(first_err_exp_b), 32'h14);
      chk("b.fem", 32'(first_err_mask_b), 32'h4);
      beat_b(pat4(16'd22));
      chk("b.suc2", suc_cnt_b, 32'd3);
      for (int k = 12; k < 16; k++) begin
         db = pat4(16'(2 * k));
         db[15:0] = db[15:0] + 16'd3;
         beat_b(db);
      end
      chk("b.lost", 32'(locked_b), 32'h0);
      chk("b.loss", 32'(loss_cnt_b), 32'd1);
      chk("b.err5", err_cnt_b, 32'd5);
      chk("b.mask2", 32'(err_lane_mask_b), 32'h5);
      for (int k = 0; k < 8; k++) beat_b(pat4(16'(32'h0100 + 2 * k)));
      chk("b.relocked", 32'(locked_b), 32'h1);
      @(negedge clk);
      cfg_rst_b  = 1'b1;
      adc_vld_b  = 1'b1;
      adc_data_b = pat4(16'h0110);
      @(posedge clk);
      #1;
      cfg_rst_b = 1'b0;
      adc_vld_b = 1'b0;
      chk("b.cfg_locked", 32'(locked_b), 32'h0);
      chk("b.cfg_err", err_cnt_b, 32'h0);
      chk("b.cfg_loss", 32'(loss_cnt_b), 32'h0);
      chk("b.cfg_fev", 32'(first_err_vld_b), 32'h0);
      chk("b.cfg_suc", suc_cnt_b, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
